uart_buffer: RTL

- Byte-buffering stage between the CPU/bus side and the `uart` serial core.
- TX side: holds bytes written by software in a FIFO and feeds them one at a time to the core through data_in/data_send, advancing on data_sent.
- RX side: captures bytes the core presents on data_out/data_received into a FIFO for software to read, with a sticky overrun flag.

---
 rtl/uart_buffer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/uart_buffer.sv
// uart_buffer: byte FIFOs between the bus side and the uart serial core.
// TX bytes are queued and handed to the core one at a time, with a one-cycle
// GAP state after each completed frame so the core never sees the same byte
// twice. RX bytes from the core are queued for software with a sticky overrun.
module uart_buffer #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // TX bus side
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  tx_full,
    output logic                  tx_empty,
    // RX bus side
    input  logic                  rd_en,
    output logic [7:0]            rd_data,
    output logic                  rx_empty,
    output logic [DEPTH_LOG2:0]   rx_count,
    output logic                  rx_overrun,
    input  logic                  overrun_clr,
    // uart core side
    output logic [7:0]            uart_data_in,
    output logic                  uart_data_send,
    input  logic                  uart_data_sent,
    input  logic [7:0]            uart_data_out,
    input  logic                  uart_data_received
);

    localparam int unsigned AW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_t;

    // ------------------------------------------------------------------
    // TX FIFO storage and control
    // ------------------------------------------------------------------
    logic [7:0]    r_tx_mem [DEPTH];
    logic [AW-1:0] r_tx_wptr;
    logic [AW-1:0] r_tx_rptr;
    logic [CW-1:0] r_tx_count;

    tx_state_t     r_tx_state;
    logic [7:0]    r_uart_data_in;
    logic          r_uart_data_send;

    logic          w_tx_full;
    logic          w_tx_fifo_empty;
    logic          w_tx_push;
    logic          w_tx_pop;

    assign w_tx_full       = (r_tx_count == FULL_COUNT);
    assign w_tx_fifo_empty = (r_tx_count == '0);
    assign w_tx_push       = wr_en && !w_tx_full;
    // The head is only retired when the core finishes the frame it was given.
    assign w_tx_pop        = (r_tx_state == ST_SEND) && uart_data_sent;

    // TX byte storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr] <= wr_data;
        end
    end

    // TX pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_wptr <= r_tx_wptr + AW'(1);
            end
            if (w_tx_pop) begin
                r_tx_rptr <= r_tx_rptr + AW'(1);
            end
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + CW'(1);
                2'b01:   r_tx_count <= r_tx_count - CW'(1);
                default: r_tx_count <= r_tx_count;
            endcase
        end
    end

    // TX handshake FSM: load head, hold until sent, then one forced idle cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state       <= ST_IDLE;
            r_uart_data_in   <= 8'h00;
            r_uart_data_send <= 1'b0;
        end else begin
            case (r_tx_state)
                ST_IDLE: begin
                    if (!w_tx_fifo_empty) begin
                        r_uart_data_in   <= r_tx_mem[r_tx_rptr];
                        r_uart_data_send <= 1'b1;
                        r_tx_state       <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (uart_data_sent) begin
                        r_uart_data_send <= 1'b0;
                        r_tx_state       <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    r_uart_data_send <= 1'b0;
                    r_tx_state       <= ST_IDLE;
                end
                default: begin
                    r_uart_data_send <= 1'b0;
                    r_tx_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign uart_data_in   = r_uart_data_in;
    assign uart_data_send = r_uart_data_send;
    assign tx_full        = w_tx_full;
    // A byte handed to the core still counts as pending until the GAP ends.
    assign tx_empty       = w_tx_fifo_empty && (r_tx_state == ST_IDLE);

    // ------------------------------------------------------------------
    // RX FIFO storage and control
    // ------------------------------------------------------------------
    logic [7:0]    r_rx_mem [DEPTH];
    logic [AW-1:0] r_rx_wptr;
    logic [AW-1:0] r_rx_rptr;
    logic [CW-1:0] r_rx_count;
    logic          r_rx_overrun;

    logic          w_rx_full;
    logic          w_rx_empty;
    logic          w_rx_push;
    logic          w_rx_pop;
    logic          w_rx_drop;

    assign w_rx_full  = (r_rx_count == FULL_COUNT);
    assign w_rx_empty = (r_rx_count == '0);
    assign w_rx_pop   = rd_en && !w_rx_empty;
    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_rx_push  = uart_data_received && (!w_rx_full || w_rx_pop);
    assign w_rx_drop  = uart_data_received && w_rx_full && !w_rx_pop;

    // RX byte storage; when full with a coincident pop the write reuses the head slot
    always_ff @(posedge clk) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= uart_data_out;
        end
    end

    // RX pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_wptr <= r_rx_wptr + AW'(1);
            end
            if (w_rx_pop) begin
                r_rx_rptr <= r_rx_rptr + AW'(1);
            end
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + CW'(1);
                2'b01:   r_rx_count <= r_rx_count - CW'(1);
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

    // Sticky overrun; a fresh drop outranks a clear in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_overrun <= 1'b0;
        end else if (w_rx_drop) begin
            r_rx_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_rx_overrun <= 1'b0;
        end
    end

    assign rx_empty   = w_rx_empty;
    assign rx_count   = r_rx_count;
    assign rx_overrun = r_rx_overrun;
    // First-word-fall-through head; forced to zero while nothing is stored.
    assign rd_data    = w_rx_empty ? 8'h00 : r_rx_mem[r_rx_rptr];

endmodule
